// File: rtl/cj_pkg.sv
// Shared types and helpers for the CJ commit queue: the buffered record layout
// and the lane popcount used to size each enqueue.
package cj_pkg;

   localparam int CJ_XLEN   = 64;
   localparam int CJ_INSN_W = 32;

   typedef struct packed {
      logic                 trap;
      logic [CJ_XLEN-1:0]   pc;
      logic [CJ_INSN_W-1:0] insn;
      logic                 wen;
      logic [4:0]           waddr;
      logic [CJ_XLEN-1:0]   wdata;
   } cj_rec_t;

   // Up to four retire lanes are supported, so a 4-bit view is sufficient.
   function automatic logic [2:0] cj_popcount(input logic [3:0] v);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < 4; i++) n = n + {2'b00, v[i]};
      return n;
   endfunction

endpackage

// File: rtl/cj_commit_queue_if.sv
// Retire-side and checker-side signal bundle of the CJ commit queue.
// The slave modport is the queue itself; the master modport is its environment.
interface cj_commit_queue_if
   import cj_pkg::*;
#(
   parameter int COMMITS = 2,
   parameter int XLEN    = 64
) ();

   logic [COMMITS-1:0]      in_valid;
   logic [COMMITS*XLEN-1:0] in_pc;
   logic [COMMITS*32-1:0]   in_insn;
   logic [COMMITS-1:0]      in_wen;
   logic [COMMITS*5-1:0]    in_waddr;
   logic [COMMITS*XLEN-1:0] in_wdata;
   logic                    trap_valid;
   logic [XLEN-1:0]         trap_cause;
   logic                    in_ready;

   logic                    out_valid;
   logic                    out_ready;
   logic                    out_trap;
   logic [XLEN-1:0]         out_pc;
   logic [CJ_INSN_W-1:0]    out_insn;
   logic                    out_wen;
   logic [4:0]              out_waddr;
   logic [XLEN-1:0]         out_wdata;

   modport master (
      output in_valid, in_pc, in_insn, in_wen, in_waddr, in_wdata,
      output trap_valid, trap_cause, out_ready,
      input  in_ready, out_valid, out_trap, out_pc, out_insn,
      input  out_wen, out_waddr, out_wdata
   );

   modport slave (
      input  in_valid, in_pc, in_insn, in_wen, in_waddr, in_wdata,
      input  trap_valid, trap_cause, out_ready,
      output in_ready, out_valid, out_trap, out_pc, out_insn,
      output out_wen, out_waddr, out_wdata
   );

endinterface

// File: rtl/cj_lane_compact.sv
// Packs the valid retire lanes (ascending lane order) followed by an optional
// trap record into consecutive slots, and reports how many slots are used.
module cj_lane_compact
   import cj_pkg::*;
#(
   parameter int COMMITS = 2
) (
   input  logic [COMMITS-1:0] lane_vld_i,
   input  cj_rec_t            lane_rec_i [COMMITS],
   input  logic               trap_vld_i,
   input  cj_rec_t            trap_rec_i,
   output cj_rec_t            slot_o     [COMMITS+1],
   output logic [2:0]         nrec_o
);

   localparam int SW = (COMMITS > 0) ? $clog2(COMMITS + 1) : 1;

   always_comb begin
      logic [SW-1:0] idx;
      for (int s = 0; s <= COMMITS; s++) slot_o[s] = '0;
      idx = '0;
      // Running prefix count of valid lanes selects each record's slot.
      for (int i = 0; i < COMMITS; i++) begin
         if (lane_vld_i[i]) begin
            slot_o[idx] = lane_rec_i[i];
            idx         = idx + SW'(1);
         end
      end
      if (trap_vld_i) slot_o[idx] = trap_rec_i;
   end

   assign nrec_o = cj_popcount(4'(lane_vld_i)) + {2'b00, trap_vld_i};

endmodule

// File: rtl/cj_commit_queue.sv
// CJ commit queue: compacts multi-lane retire records plus a trap into a FIFO
// and serializes them to the checker. Optional trace: define CJ_COMMIT_TRACE_EN.
module cj_commit_queue
   import cj_pkg::*;
#(
   parameter int COMMITS = 2,
   parameter int DEPTH   = 16,
   parameter int XLEN    = 64,
   parameter int TIMEOUT = 100000
) (
   input  logic                       clock,
   input  logic                       reset,
   cj_commit_queue_if.slave           bus,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       hang
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   cj_rec_t       lane_rec [COMMITS];
   cj_rec_t       trap_rec;
   cj_rec_t       slot     [COMMITS+1];
   logic [2:0]    nrec;

   cj_rec_t       mem_q    [DEPTH];
   cj_rec_t       head;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          in_rdy, any_in, enq, deq, out_vld;

   always_comb begin
      for (int i = 0; i < COMMITS; i++) begin
         lane_rec[i]       = '0;
         lane_rec[i].pc    = CJ_XLEN'(bus.in_pc[i*XLEN +: XLEN]);
         lane_rec[i].insn  = bus.in_insn[i*CJ_INSN_W +: CJ_INSN_W];
         lane_rec[i].wen   = bus.in_wen[i];
         lane_rec[i].waddr = bus.in_waddr[i*5 +: 5];
         lane_rec[i].wdata = CJ_XLEN'(bus.in_wdata[i*XLEN +: XLEN]);
      end
      trap_rec       = '0;
      trap_rec.trap  = 1'b1;
      trap_rec.wdata = CJ_XLEN'(bus.trap_cause);
   end

   cj_lane_compact #(.COMMITS(COMMITS)) u_compact (
      .lane_vld_i (bus.in_valid),
      .lane_rec_i (lane_rec),
      .trap_vld_i (bus.trap_valid),
      .trap_rec_i (trap_rec),
      .slot_o     (slot),
      .nrec_o     (nrec)
   );

   // Admission uses registered occupancy only, so a full cycle's worth always fits.
   assign in_rdy  = (count_q <= CW'(DEPTH - COMMITS - 1));
   assign any_in  = (|bus.in_valid) | bus.trap_valid;
   assign enq     = in_rdy & any_in;
   assign out_vld = (count_q != '0);
   assign deq     = out_vld & bus.out_ready;

   always_comb begin
      rd_ptr_d = rd_ptr_q + (deq ? AW'(1) : '0);
      wr_ptr_d = wr_ptr_q + (enq ? AW'(nrec) : '0);
      count_d  = count_q + (enq ? CW'(nrec) : '0) - (deq ? CW'(1) : '0);
      ovf_d    = ovf_q | (any_in & ~in_rdy);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage carries no reset; the cleared pointers make stale entries invisible.
   always_ff @(posedge clock) begin
      if (enq) begin
         for (int s = 0; s <= COMMITS; s++) begin
            if (3'(s) < nrec) mem_q[wr_ptr_q + AW'(s)] <= slot[s];
         end
      end
   end

   assign head          = mem_q[rd_ptr_q];
   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_vld;
   assign bus.out_trap  = out_vld ? head.trap : 1'b0;
   assign bus.out_pc    = out_vld ? XLEN'(head.pc) : '0;
   assign bus.out_insn  = out_vld ? head.insn : '0;
   assign bus.out_wen   = out_vld ? head.wen : 1'b0;
   assign bus.out_waddr = out_vld ? head.waddr : '0;
   assign bus.out_wdata = out_vld ? XLEN'(head.wdata) : '0;
   assign count         = count_q;
   assign overflow      = ovf_q;

   generate
      if (TIMEOUT > 0) begin : g_hang
         logic [TW-1:0] tmo_q, tmo_d;
         logic          hang_q;

         always_comb begin
            tmo_d = tmo_q;
            if (enq)                         tmo_d = '0;
            else if (tmo_q != TW'(TIMEOUT))  tmo_d = tmo_q + TW'(1);
         end

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               tmo_q  <= '0;
               hang_q <= 1'b0;
            end else begin
               tmo_q  <= tmo_d;
               hang_q <= hang_q | (tmo_d == TW'(TIMEOUT));
            end
         end

         assign hang = hang_q;
      end else begin : g_no_hang
         assign hang = 1'b0;
      end
   endgenerate

`ifdef CJ_COMMIT_TRACE_EN
   logic [63:0] trace_cyc_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         trace_cyc_q <= '0;
      end else begin
         trace_cyc_q <= trace_cyc_q + 64'd1;
         if (deq) begin
            if (head.trap)
               $display("%0d [CJ] trap cause=%h", trace_cyc_q, XLEN'(head.wdata));
            else
               $display("%0d [CJ] pc=%h insn=%h wen=%b rd=%0d wdata=%h", trace_cyc_q,
                        XLEN'(head.pc), head.insn, head.wen, head.waddr, XLEN'(head.wdata));
         end
      end
   end
`endif

endmodule

// File: tb/tb_cj_commit_queue.sv
// Scoreboard bench for cj_commit_queue (COMMITS=2, DEPTH=16, XLEN=64, TIMEOUT=8).
module tb_cj_commit_queue;

   typedef struct {
      logic        trap;
      logic [63:0] pc;
      logic [31:0] insn;
      logic        wen;
      logic [4:0]  waddr;
      logic [63:0] wdata;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] count;
   logic       overflow;
   logic       hang;

   exp_t sbq[$];
   bit   exp_ovf = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clock = ~clock;

   cj_commit_queue_if #(.COMMITS(2), .XLEN(64)) bus ();

   cj_commit_queue #(.COMMITS(2), .DEPTH(16), .XLEN(64), .TIMEOUT(8)) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus),
      .count    (count),
      .overflow (overflow),
      .hang     (hang)
   );

   task automatic clear_inputs();
      bus.in_valid   = '0;
      bus.in_pc      = '0;
      bus.in_insn    = '0;
      bus.in_wen     = '0;
      bus.in_waddr   = '0;
      bus.in_wdata   = '0;
      bus.trap_valid = 1'b0;
      bus.trap_cause = '0;
   endtask

   task automatic set_lane(input int i, input logic [63:0] pc, input logic [31:0] insn,
                           input logic wen, input logic [4:0] rd, input logic [63:0] wd);
      bus.in_valid[i]          = 1'b1;
      bus.in_pc[i*64 +: 64]    = pc;
      bus.in_insn[i*32 +: 32]  = insn;
      bus.in_wen[i]            = wen;
      bus.in_waddr[i*5 +: 5]   = rd;
      bus.in_wdata[i*64 +: 64] = wd;
   endtask

   // One clock: check current outputs against the model, then advance the model.
   task automatic step();
      bit   any, deq, acc;
      exp_t e;
      #1;
      total++;
      if (bus.out_valid !== (sbq.size() != 0)) begin
         bad++; $display("FAIL out_valid: got %b want %b", bus.out_valid, sbq.size() != 0);
      end
      total++;
      if (bus.in_ready !== (sbq.size() <= 13)) begin
         bad++; $display("FAIL in_ready: got %b want %b", bus.in_ready, sbq.size() <= 13);
      end
      total++;
      if (count !== 5'(sbq.size())) begin
         bad++; $display("FAIL count: got %0d want %0d", count, sbq.size());
      end
      total++;
      if (overflow !== exp_ovf) begin
         bad++; $display("FAIL overflow: got %b want %b", overflow, exp_ovf);
      end
      if (sbq.size() != 0) begin
         e = sbq[0];
         total++;
         if ({bus.out_trap, bus.out_pc, bus.out_insn, bus.out_wen, bus.out_waddr, bus.out_wdata} !==
             {e.trap, e.pc, e.insn, e.wen, e.waddr, e.wdata}) begin
            bad++;
            $display("FAIL head: got trap=%b pc=%h insn=%h wen=%b rd=%0d wd=%h want trap=%b pc=%h insn=%h wen=%b rd=%0d wd=%h",
                     bus.out_trap, bus.out_pc, bus.out_insn, bus.out_wen, bus.out_waddr, bus.out_wdata,
                     e.trap, e.pc, e.insn, e.wen, e.waddr, e.wdata);
         end
      end
      any = (bus.in_valid != 2'b00) || bus.trap_valid;
      acc = (sbq.size() <= 13);
      deq = (sbq.size() != 0) && bus.out_ready;
      if (any && !acc) exp_ovf = 1'b1;
      if (deq) void'(sbq.pop_front());
      if (any && acc) begin
         for (int i = 0; i < 2; i++) begin
            if (bus.in_valid[i]) begin
               e.trap = 1'b0; e.pc = bus.in_pc[i*64 +: 64]; e.insn = bus.in_insn[i*32 +: 32];
               e.wen = bus.in_wen[i]; e.waddr = bus.in_waddr[i*5 +: 5]; e.wdata = bus.in_wdata[i*64 +: 64];
               sbq.push_back(e);
            end
         end
         if (bus.trap_valid) begin
            e.trap = 1'b1; e.pc = '0; e.insn = '0; e.wen = 1'b0; e.waddr = '0; e.wdata = bus.trap_cause;
            sbq.push_back(e);
         end
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      clear_inputs();
      bus.out_ready = 1'b0;
      sbq.delete();
      exp_ovf = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic drain(input string name);
      int n;
      clear_inputs();
      bus.out_ready = 1'b1;
      n = 0;
      while (sbq.size() != 0 && n < 40) begin
         step();
         n++;
      end
      total++;
      if (sbq.size() != 0) begin
         bad++; $display("FAIL %s drain timeout: left %0d want 0", name, sbq.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      set_lane(0, 64'h8000_1000, 32'h0000_0013, 1'b1, 5'd1, 64'h11);
      set_lane(1, 64'h8000_1004, 32'h0000_0093, 1'b0, 5'd2, 64'h22);
      bus.trap_valid = 1'b1; bus.trap_cause = 64'h7;
      step();
      clear_inputs();
      set_lane(0, 64'h8000_1008, 32'h0000_0113, 1'b1, 5'd3, 64'h33);
      set_lane(1, 64'h8000_100c, 32'h0000_0193, 1'b1, 5'd4, 64'h44);
      step();
      clear_inputs();
      total++;
      if (count !== 5'd5) begin bad++; $display("FAIL reset_precount: got %0d want 5", count); end
      #2 reset = 1'b0;
      #1;
      total++;
      if ({bus.out_valid, count, overflow, hang, bus.in_ready} !== {1'b0, 5'd0, 1'b0, 1'b0, 1'b1}) begin
         bad++; $display("FAIL reset_async: got vld=%b cnt=%0d ovf=%b hang=%b rdy=%b want 0 0 0 0 1",
                         bus.out_valid, count, overflow, hang, bus.in_ready);
      end
      total++;
      if ({bus.out_pc, bus.out_wdata, bus.out_insn, bus.out_waddr, bus.out_trap, bus.out_wen} !== '0) begin
         bad++; $display("FAIL reset_data: got pc=%h wd=%h want 0", bus.out_pc, bus.out_wdata);
      end
      sbq.delete();
      exp_ovf = 1'b0;
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_hang();
      do_reset();
      for (int k = 0; k < 7; k++) step();
      total++;
      if (hang !== 1'b0) begin bad++; $display("FAIL hang_early: got %b want 0", hang); end
      step();
      total++;
      if (hang !== 1'b1) begin bad++; $display("FAIL hang_set: got %b want 1", hang); end
      set_lane(0, 64'h8000_2000, 32'h1, 1'b0, 5'd0, 64'h0);
      step();
      drain("hang");
      total++;
      if (hang !== 1'b1) begin bad++; $display("FAIL hang_sticky: got %b want 1", hang); end
      do_reset();
      #1;
      total++;
      if (hang !== 1'b0) begin bad++; $display("FAIL hang_clear: got %b want 0", hang); end
   endtask

   task automatic test_burst();
      do_reset();
      bus.out_ready = 1'b1;
      set_lane(0, 64'h8000_0000, 32'h0000_0513, 1'b1, 5'd10, 64'h1);
      set_lane(1, 64'h8000_0004, 32'h0000_0593, 1'b1, 5'd11, 64'h2);
      step();
      clear_inputs();
      total++;
      if ({count, bus.out_pc} !== {5'd2, 64'h8000_0000}) begin
         bad++; $display("FAIL burst_first: got cnt=%0d pc=%h want 2 80000000", count, bus.out_pc);
      end
      step();
      total++;
      if ({count, bus.out_pc} !== {5'd1, 64'h8000_0004}) begin
         bad++; $display("FAIL burst_second: got cnt=%0d pc=%h want 1 80000004", count, bus.out_pc);
      end
      drain("burst");
   endtask

   task automatic test_sparse();
      bus.out_ready = 1'b0;
      set_lane(1, 64'h8000_0010, 32'h0050_0293, 1'b1, 5'd5, 64'hdead);
      step();
      clear_inputs();
      total++;
      if ({count, bus.out_wen, bus.out_waddr, bus.out_wdata} !== {5'd1, 1'b1, 5'd5, 64'hdead}) begin
         bad++; $display("FAIL sparse: got cnt=%0d wen=%b rd=%0d wd=%h want 1 1 5 dead",
                         count, bus.out_wen, bus.out_waddr, bus.out_wdata);
      end
      step();
      drain("sparse");
   endtask

   task automatic test_trap();
      bus.out_ready = 1'b1;
      set_lane(0, 64'h8000_0020, 32'h0000_0073, 1'b0, 5'd0, 64'h0);
      bus.trap_valid = 1'b1; bus.trap_cause = 64'h2;
      step();
      clear_inputs();
      total++;
      if ({bus.out_pc, bus.out_trap} !== {64'h8000_0020, 1'b0}) begin
         bad++; $display("FAIL trap_lane: got pc=%h trap=%b want 80000020 0", bus.out_pc, bus.out_trap);
      end
      step();
      total++;
      if ({bus.out_trap, bus.out_wdata, bus.out_pc} !== {1'b1, 64'h2, 64'h0}) begin
         bad++; $display("FAIL trap_rec: got trap=%b wd=%h pc=%h want 1 2 0", bus.out_trap, bus.out_wdata, bus.out_pc);
      end
      drain("trap");
   endtask

   task automatic test_fill_overflow();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         set_lane(0, 64'h9000_0000 + 64'(k*16), 32'(k), 1'b1, 5'(k), 64'(k));
         set_lane(1, 64'h9000_0004 + 64'(k*16), 32'(k+100), 1'b0, 5'(k+1), 64'(k+200));
         bus.trap_valid = 1'b1; bus.trap_cause = 64'(k+300);
         step();
      end
      total++;
      if ({count, bus.in_ready, overflow} !== {5'd15, 1'b0, 1'b0}) begin
         bad++; $display("FAIL fill: got cnt=%0d rdy=%b ovf=%b want 15 0 0", count, bus.in_ready, overflow);
      end
      step();
      clear_inputs();
      total++;
      if ({count, overflow} !== {5'd15, 1'b1}) begin
         bad++; $display("FAIL overflow: got cnt=%0d ovf=%b want 15 1", count, overflow);
      end
      drain("fill");
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 80; k++) begin
         clear_inputs();
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(1) == 1)
               set_lane(i, {$urandom, $urandom}, $urandom, 1'($urandom_range(1)),
                        5'($urandom_range(31)), {$urandom, $urandom});
         end
         if ($urandom_range(3) == 0) begin
            bus.trap_valid = 1'b1; bus.trap_cause = {32'h0, $urandom};
         end
         bus.out_ready = ($urandom_range(2) != 0);
         step();
      end
      drain("b2b");
   endtask

   initial begin
      clear_inputs();
      bus.out_ready = 1'b0;
      test_reset();
      test_hang();
      test_burst();
      test_sparse();
      test_trap();
      test_fill_overflow();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cj_commit_queue.md
Name: cj_commit_queue

Overview:
- Multi-lane commit buffer for the co-simulation checker (CJ) path.
- Captures up to COMMITS retired instructions plus one trap per cycle from a core's retire stage and compacts them in program order.
- Buffers records in a DEPTH-entry FIFO and presents them one per cycle over a valid/ready port to the checker, decoupling core retire bursts from serialized cosim calls.
- Also flags overflow and retire hangs.

Parameters:
- COMMITS, 2, number of retire lanes (1..4)
- DEPTH, 16, FIFO entries; power of two, >= COMMITS+1
- XLEN, 64, PC/data width
- TIMEOUT, 100000, cycles without any enqueue before hang asserts; 0 disables the hang detector

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  COMMITS  per-lane commit valid; any bit pattern is legal
- in_pc  in  COMMITS*XLEN  lane PCs; lane i at [i*XLEN +: XLEN]
- in_insn  in  COMMITS*32  lane instruction words
- in_wen  in  COMMITS  lane register write enable
- in_waddr  in  COMMITS*5  lane destination register
- in_wdata  in  COMMITS*XLEN  lane writeback data
- trap_valid  in  1  trap raised this cycle, ordered after all lanes
- trap_cause  in  XLEN  trap cause
- in_ready  out  1  free entries >= COMMITS+1
- out_valid  out  1  head record valid
- out_ready  in  1  checker accepts head
- out_trap  out  1  head is a trap record
- out_pc  out  XLEN  head PC (0 for trap records)
- out_insn  out  32  head instruction (0 for trap records)
- out_wen  out  1  head writeback enable (0 for trap records)
- out_waddr  out  5  head destination (0 for trap records)
- out_wdata  out  XLEN  head wdata; holds trap_cause for trap records
- count  out  $clog2(DEPTH+1)  current occupancy
- overflow  out  1  sticky; input dropped
- hang  out  1  sticky; timeout expired

Behaviour:
- Reset (reset=0, async):
  - Pointers, count, overflow, hang and timeout counter clear.
  - out_valid=0; in_ready=1.
  - All out_* data fields read 0.
- Enqueue (cycle N) when in_ready=1 and any of in_valid or trap_valid is set:
  - Valid lanes are compacted in ascending lane order into consecutive slots at the tail.
  - A trap record follows them in the same cycle.
  - Records enqueued = popcount(in_valid) + trap_valid, range 0..COMMITS+1.
- Latency: a record enqueued in cycle N is visible at the head in cycle N+1 at the earliest. There is no input-to-output combinational path.
- Dequeue: occurs on out_valid && out_ready. Head data is held stable while out_valid=1 and out_ready=0.
- Simultaneous enqueue and dequeue: count_next = count + enq - deq, computed in one cycle.
- Pointers wrap modulo DEPTH.
- Full boundary: in_ready is computed from registered count only and does not depend on same-cycle dequeue.
- Inputs while in_ready=0:
  - All records of that cycle are dropped; no partial enqueue.
  - overflow sets and stays set until reset.
  - count is unchanged except by dequeue.
- Empty boundary: out_valid=0; out_ready is ignored.
- Hang detector:
  - Counter resets on any enqueue and saturates at TIMEOUT.
  - hang sets when the counter reaches TIMEOUT and stays set until reset.
  - The counter runs whether or not the FIFO is empty.
- Reset mid-operation flushes all entries immediately and asynchronously; no in-flight record survives.

Optional Feature:
- Macro: CJ_COMMIT_TRACE_EN.
- Defined: on each dequeue, a $display line is printed, "[CJ] pc=%h insn=%h wen=%b rd=%0d wdata=%h" or "[CJ] trap cause=%h", with the cycle count prefixed. Trace output is simulation-only.
- Undefined: no display code is compiled; logic is identical.

Decomposition:
- Package cj_pkg:
  - cj_rec_t packed struct {trap, pc, insn, wen, waddr, wdata}
  - CJ_XLEN and CJ_INSN_W constants
  - Function cj_popcount
- Sub-module cj_lane_compact:
  - Combinational prefix-sum compaction of COMMITS lanes plus trap into COMMITS+1 ordered slots with a valid count.
  - Instantiated once.

Test Plan:
- Reset asserted low mid-burst with count=5:
  - Outputs clear asynchronously: out_valid=0, count=0, overflow=0, hang=0, in_ready=1.
- Burst order: in_valid=2'b11, pc 0x80000000/0x80000004, out_ready=1:
  - out_pc 0x80000000 in cycle N+1, then 0x80000004 in cycle N+2.
  - count peaks at 2.
- Sparse lane: in_valid=2'b10, pc 0x80000010, wen=1, waddr=5, wdata=0xdead:
  - Single record, count=1.
  - Head shows rd 5 and wdata 0xdead.
- Trap ordering: lane0 pc 0x80000020 plus trap_valid with cause 0x2 in the same cycle:
  - Head 0x80000020 (out_trap=0).
  - Then a trap record with out_trap=1, out_wdata=0x2, out_pc=0.
- Fill and overflow (DEPTH=16, COMMITS=2): hold out_ready=0, push 3 records/cycle:
  - in_ready drops once count reaches 15.
  - A push with in_ready=0 gives overflow=1 with count unchanged at 15.
  - Raising out_ready drains all 15 records in order.
- Hang (TIMEOUT=8): no input for 8 cycles after reset:
  - hang=1 on the 8th cycle.
  - A later enqueue does not clear hang; only reset clears it.
